// File: rtl/ifetch.sv
// ifetch: instruction fetch unit with a two-entry fetch buffer.
//
// Issues one sequential fetch address per cycle to a registered instruction
// memory. Returned words, tagged with their address, are queued for decode.
// Redirects flush the buffer and the in-flight fetch. Halt stops new issue
// while the buffer keeps draining.
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   pc_out         fetch address to instruction memory
//   inst_in        instruction word, valid one cycle after its pc_out
//   halt           level, suppresses new fetch issue
//   redirect_valid single-cycle flush + new fetch address request
//   redirect_pc    new fetch address (word aligned internally)
//   if_valid       buffer head holds a valid instruction
//   if_ready       decode accepts the head this cycle
//   if_inst        instruction word at the buffer head
//   if_pc          address of if_inst
module ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] inst_in,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic {StRun, StHalted} state_e;

  state_e state_q, state_d;

  logic [31:0]     pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [31:0]     inflight_pc_q, inflight_pc_d;
  logic            head_q, head_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     buf_pc_q   [2];
  logic [31:0]     buf_inst_q [2];

  logic            pop;
  logic            wr;
  logic            tail;
  logic            issue_ok;
  logic            fetch;
  logic [2:0]      occ;

  logic            unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect intentionally does not affect the state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (halt)  state_d = StHalted;
      StHalted: if (!halt) state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // Halt is a level: dropping it resumes issue in that same cycle, so HALTED
  // also keys off the live input rather than waiting for the state to flip.
  always_comb begin
    issue_ok = 1'b0;
    unique case (state_q)
      StRun:    issue_ok = !halt;
      StHalted: issue_ok = !halt;
      default:  issue_ok = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Buffer head and handshake
  // ---------------------------------------------------------------------------
  assign if_valid = (count_q != '0) && !redirect_valid;
  assign if_inst  = buf_inst_q[head_q];
  assign if_pc    = buf_pc_q[head_q];
  assign pc_out   = pc_q;

  assign pop  = if_valid && if_ready;
  assign wr   = inflight_q && !redirect_valid;
  // Write goes after the current occupants; a full buffer is never written.
  assign tail = head_q ^ count_q[0];

  // Slots committed after this edge: occupants plus the returning word minus a pop.
  assign occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign fetch = !rst && issue_ok && !redirect_valid && (occ < 3'(DEPTH));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    head_d        = head_q;
    count_d       = count_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      head_d  = 1'b0;
      count_d = '0;
    end else begin
      if (fetch) begin
        pc_d          = pc_q + 32'd4;
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      count_d = count_q + CntW'(wr) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= {RESET_PC[31:2], 2'b00};
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_q        <= 1'b0;
      count_q       <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_pc_q[i]   <= '0;
        buf_inst_q[i] <= '0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      count_q       <= count_d;
      if (wr) begin
        buf_pc_q[tail]   <= inflight_pc_q;
        buf_inst_q[tail] <= inst_in;
      end
    end
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset; bits [1:0] shall be 0.
REQ-002 Parameter DEPTH, fixed at 2: entries in the fetch buffer; no other value is supported.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pc_out  output  32  fetch address driven to the instruction memory.
REQ-006 inst_in  input  32  instruction word from the instruction memory; registered, valid exactly 1 cycle after the matching pc_out.
REQ-007 halt  input  1  level; while high, no new fetch is issued.
REQ-008 redirect_valid  input  1  single-cycle pulse requesting a flush and a new fetch address.
REQ-009 redirect_pc  input  32  new fetch address; sampled when redirect_valid=1.
REQ-010 if_valid  output  1  head of the buffer holds a valid instruction.
REQ-011 if_ready  input  1  decode stage accepts the head this cycle.
REQ-012 if_inst  output  32  instruction word at the buffer head.
REQ-013 if_pc  output  32  address of if_inst.

Function
REQ-014 Definitions: count = buffer entries (0..2); inflight = 1 if a fetch was issued last cycle and not killed; pop = if_valid && if_ready.
REQ-015 A fetch shall be issued in a cycle when: rst=0, halt=0, redirect_valid=0, and (count + inflight - pop) < 2.
REQ-016 On issue, inflight shall be set to 1 and inflight_pc shall be set to pc_out for the next cycle; pc_out shall advance by 4.
REQ-017 Advancing pc_out from 32'hFFFF_FFFC shall wrap to 32'h0000_0000.
REQ-018 When no fetch is issued, pc_out shall hold its value.
REQ-019 In a cycle with inflight=1 and no redirect, {inflight_pc, inst_in} shall be written to the buffer tail.
REQ-020 The buffer shall be FIFO-ordered and shall accept a write and a pop in the same cycle.
REQ-021 The buffer shall never overflow: REQ-015 guarantees a free slot for every returning fetch.
REQ-022 if_valid = (count != 0) && !redirect_valid.
REQ-023 if_inst and if_pc shall present the head entry combinationally; their values are don't-care when if_valid=0.
REQ-024 Once asserted, if_valid shall remain high and if_inst/if_pc stable until pop or redirect.
REQ-025 Sustained throughput: with halt=0 and if_ready=1, one instruction per cycle after a 2-cycle startup (issue, then return).
REQ-026 Redirect in cycle t:
  - the buffer is emptied and inflight is cleared at the edge ending cycle t, so the word returning in t+1 is discarded;
  - no issue occurs in cycle t;
  - pc_out = {redirect_pc[31:2], 2'b00} in cycle t+1, and issue resumes under REQ-015.
REQ-027 Redirect shall take priority over halt, pop, and buffer write in the same cycle.
REQ-028 Halt: the in-flight fetch still completes into the buffer, and the buffer keeps draining. Deasserting halt resumes issue at the held pc_out in the same cycle.
REQ-029 FSM states:
  - RUN: issue permitted.
  - HALTED: entered at the edge where halt=1; returns to RUN at the edge where halt=0.
  - A redirect does not change the state.

Reset
REQ-030 While rst=1: pc_out=RESET_PC, count=0, inflight=0, if_valid=0, FSM=RUN, buffer contents=0.
REQ-031 The first issue shall occur in the first cycle with rst=0; inst_in during reset cycles shall be ignored.
REQ-032 Asserting rst mid-operation shall discard all buffered and in-flight instructions and apply REQ-030 from the next edge.

Verification
(imem loaded with mem[k] = 32'h1000_0000 + k; RESET_PC=0)
REQ-033 Release rst, halt=0, if_ready=1 -> pc_out=0,4,8,... one per cycle; first if_valid at cycle 2 with if_pc=0, if_inst=32'h1000_0000; then one instruction per cycle, consecutive.
REQ-034 if_ready=0 from cycle 2 -> count reaches 2 (pc 0 and 4), pc_out holds at 8, no loss. Raise if_ready -> outputs 0, 4, 8, 12 in order.
REQ-035 redirect_valid=1 with redirect_pc=32'h0000_0043 while the buffer is full -> if_valid=0 in that cycle and the next; pc_out=32'h0000_0040 next cycle; the next accepted if_pc=0x40 with if_inst=32'h1000_0010; old entries never appear.
REQ-036 halt=1 for 5 cycles with if_ready=1 -> at most one further issue; the buffer drains; pc_out is constant. Release -> the stream continues with no gap in addresses.
REQ-037 Redirect to 32'hFFFF_FFF8 -> pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 rst=1 for 1 cycle mid-stream with the buffer full -> if_valid=0 the next cycle, pc_out=0; the stream restarts at if_pc=0.
